demux_32_8: RTL

- Word-to-byte serializer: the transmit-side counterpart of the 8→32 byte packer.
- Accepts one 32-bit word per handshake and emits it as four consecutive 8-bit beats with a valid strobe, one beat per clock on the fast (4f) domain.
- Holds one word in a holding register while the previous word is being shifted out, so a word presented every 4 cycles streams gap-free.
- Sits between the 32-bit datapath and the byte-wide serial lane.

---
 rtl/demux_32_8_if.sv | 27 ++
 rtl/demux_32_8.sv | 123 ++++++++++++
 2 files changed

// File: rtl/demux_32_8_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : demux_32_8_if                                                   |
// | Brief    : Word-in / byte-out bus bundle for the 32->8 serializer.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface demux_32_8_if;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        last_out;

  // Sender / byte-lane consumer side
  modport master (
    output data_in, valid_in,
    input  ready_out, data_out, valid_out, last_out
  );

  // Serializer side
  modport slave (
    input  data_in, valid_in,
    output ready_out, data_out, valid_out, last_out
  );
endinterface
`default_nettype wire

// File: rtl/demux_32_8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : demux_32_8                                                      |
// | Brief    : 32-bit word to 8-bit beat serializer with one-word holding reg; |
// |            LSB_FIRST_EN (define) reverses the byte order.                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module demux_32_8 #(
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input wire          clk_4f,
  input wire          reset_L,
  demux_32_8_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_byte_idx;
  logic [1:0]  w_byte_idx_nxt;
  logic [31:0] r_hold;
  logic        r_hold_full;
  logic [31:0] r_shift;
  logic [31:0] w_shift_nxt;
  logic [7:0]  r_data_out;
  logic [7:0]  w_data_nxt;
  logic        r_valid_out;
  logic        w_valid_nxt;
  logic        r_last_out;
  logic        w_last_nxt;
  logic        w_accept;
  logic        w_load;

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
`ifdef LSB_FIRST_EN
    case (idx)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
`else
    case (idx)
      2'd0:    byte_sel = word[31:24];
      2'd1:    byte_sel = word[23:16];
      2'd2:    byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase
`endif
  endfunction

  // Load needs hold_full, accept needs !hold_full, so they are mutually exclusive
  assign w_accept = bus.valid_in & ~r_hold_full;
  assign w_load   = r_hold_full & ((r_state == IDLE) | (r_byte_idx == 2'd3));

  always_comb begin
    w_state_nxt    = r_state;
    w_byte_idx_nxt = r_byte_idx;
    w_shift_nxt    = r_shift;
    w_data_nxt     = r_data_out;
    w_valid_nxt    = r_valid_out;
    w_last_nxt     = r_last_out;
    if (w_load) begin
      w_state_nxt    = SEND;
      w_byte_idx_nxt = 2'd0;
      w_shift_nxt    = r_hold;
      w_data_nxt     = byte_sel(r_hold, 2'd0);
      w_valid_nxt    = 1'b1;
      w_last_nxt     = 1'b0;
    end else if (r_state == SEND) begin
      if (r_byte_idx != 2'd3) begin
        w_byte_idx_nxt = r_byte_idx + 2'd1;
        w_data_nxt     = byte_sel(r_shift, r_byte_idx + 2'd1);
        w_valid_nxt    = 1'b1;
        w_last_nxt     = (r_byte_idx == 2'd2);
      end else begin
        w_state_nxt    = IDLE;
        w_data_nxt     = IDLE_BYTE;
        w_valid_nxt    = 1'b0;
        w_last_nxt     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= IDLE;
      r_byte_idx  <= 2'd0;
      r_hold      <= 32'd0;
      r_hold_full <= 1'b0;
      r_shift     <= 32'd0;
      r_data_out  <= IDLE_BYTE;
      r_valid_out <= 1'b0;
      r_last_out  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_byte_idx  <= w_byte_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_data_out  <= w_data_nxt;
      r_valid_out <= w_valid_nxt;
      r_last_out  <= w_last_nxt;
      if (w_accept) begin
        r_hold <= bus.data_in;
      end
      if (w_load) begin
        r_hold_full <= 1'b0;
      end else if (w_accept) begin
        r_hold_full <= 1'b1;
      end
    end
  end

  assign bus.ready_out = ~r_hold_full;
  assign bus.data_out  = r_data_out;
  assign bus.valid_out = r_valid_out;
  assign bus.last_out  = r_last_out;

endmodule
`default_nettype wire
